wb_arbiter: RTL

Writeback arbiter and write-port driver for the 32x32 register file. Accepts results from two producers, the ALU (port A) and the load/store unit (port B), over valid/ready handshakes. Buffers each source in its own FIFO, round-robin arbitrates between them, and drives the register file's single write port (wr_en/wr_addr/wr_data) from a registered output stage.

---
 rtl/wb_arbiter_if.sv | 68 ++++++
 rtl/wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: producer handshakes (ALU = port A,
// LSU = port B), flush, and the register-file write port.
// pending_mask exists only when WB_PENDING_EN is defined.
// slave  : arbiter view (consumes results, drives the write port)
// master : environment view (producers, flush source, register file)
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              flush;

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              idle;

`ifdef WB_PENDING_EN
  logic [31:0]       pending_mask;

  modport slave (
    input  flush,
    input  a_valid, a_rd, a_data,
    output a_ready,
    input  b_valid, b_rd, b_data,
    output b_ready,
    output wr_en, wr_addr, wr_data, idle,
    output pending_mask
  );

  modport master (
    output flush,
    output a_valid, a_rd, a_data,
    input  a_ready,
    output b_valid, b_rd, b_data,
    input  b_ready,
    input  wr_en, wr_addr, wr_data, idle,
    input  pending_mask
  );
`else
  modport slave (
    input  flush,
    input  a_valid, a_rd, a_data,
    output a_ready,
    input  b_valid, b_rd, b_data,
    output b_ready,
    output wr_en, wr_addr, wr_data, idle
  );

  modport master (
    output flush,
    output a_valid, a_rd, a_data,
    input  a_ready,
    output b_valid, b_rd, b_data,
    input  b_ready,
    input  wr_en, wr_addr, wr_data, idle
  );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the 32x32 register file.
// Two producers (ALU = A, LSU = B) each feed a DEPTH-entry FIFO; the FIFO
// heads are round-robin arbitrated (pointer moves only on contention) and
// the winner is registered onto the single register-file write port.
// Entries targeting x0 consume an arbitration slot but never assert wr_en.
// Optional: define WB_PENDING_EN to add pending_mask, a per-register
// scoreboard of writes still queued or currently on the write port.
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam int               NSRC     = 2;

  // round-robin pointer encoding: which source wins the next contended slot
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  // per-source FIFO storage and bookkeeping, index 0 = A, 1 = B
  logic [ADDR_W-1:0] rd_mem   [NSRC][DEPTH];
  logic [DATA_W-1:0] data_mem [NSRC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [NSRC];
  logic [PTR_W-1:0]  rd_ptr   [NSRC];
  logic [CNT_W-1:0]  count    [NSRC];

  logic              rr;

  // per-source handshake view
  logic [NSRC-1:0]   in_valid;
  logic [ADDR_W-1:0] in_rd    [NSRC];
  logic [DATA_W-1:0] in_data  [NSRC];
  logic [NSRC-1:0]   ready;
  logic [NSRC-1:0]   not_empty;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;

  // selected head entry
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              head_writes;

  // registered write port
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // gather both producer ports into indexable form
  always_comb begin
    in_valid   = {bus.b_valid, bus.a_valid};
    in_rd[0]   = bus.a_rd;
    in_rd[1]   = bus.b_rd;
    in_data[0] = bus.a_data;
    in_data[1] = bus.b_data;
  end

  // ready depends on the count register only, so a same-cycle pop never frees a slot early
  always_comb begin
    ready     = '0;
    not_empty = '0;
    push      = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      ready[s]     = (count[s] != FULL_CNT);
      not_empty[s] = (count[s] != '0);
      push[s]      = in_valid[s] && ready[s];
    end
  end

  // one pop per cycle: lone head wins outright, contention goes to the RR pointer
  always_comb begin
    pop = '0;
    if (not_empty[0] && not_empty[1]) begin
      pop = (rr == RR_A) ? 2'b01 : 2'b10;
    end else begin
      pop = not_empty;
    end
    if (pop[1]) begin
      head_rd   = rd_mem[1][rd_ptr[1]];
      head_data = data_mem[1][rd_ptr[1]];
    end else begin
      head_rd   = rd_mem[0][rd_ptr[0]];
      head_data = data_mem[0][rd_ptr[0]];
    end
    head_writes = (|pop) && (head_rd != '0);
  end

  // FIFO pointers and occupancy; flush overrides any push or pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else if (bus.flush) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (push[s]) begin
          wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
        end
        if (pop[s]) begin
          rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        end
        if (push[s] && !pop[s]) begin
          count[s] <= count[s] + CNT_W'(1);
        end else if (!push[s] && pop[s]) begin
          count[s] <= count[s] - CNT_W'(1);
        end
      end
    end
  end

  // FIFO payload storage; no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (push[s] && !bus.flush) begin
        rd_mem[s][wr_ptr[s]]   <= in_rd[s];
        data_mem[s][wr_ptr[s]] <= in_data[s];
      end
    end
  end

  // round-robin pointer flips only when both heads competed for the slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr <= RR_A;
    end else if (bus.flush) begin
      rr <= RR_A;
    end else if (not_empty[0] && not_empty[1]) begin
      rr <= ~rr;
    end
  end

  // output stage: one-cycle write pulse per popped non-x0 entry, address/data hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (bus.flush) begin
      wr_en_q   <= 1'b0;
    end else if (head_writes) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= head_rd;
      wr_data_q <= head_data;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  // drive the bus outputs
  always_comb begin
    bus.a_ready = ready[0];
    bus.b_ready = ready[1];
    bus.wr_en   = wr_en_q;
    bus.wr_addr = wr_addr_q;
    bus.wr_data = wr_data_q;
    bus.idle    = !not_empty[0] && !not_empty[1] && !wr_en_q;
  end

`ifdef WB_PENDING_EN
  logic [31:0]      pend;
  logic [PTR_W-1:0] offs;

  // a slot is live when its distance from the read pointer is below the count
  always_comb begin
    pend = '0;
    offs = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        offs = PTR_W'(i) - rd_ptr[s];
        if (CNT_W'(offs) < count[s]) begin
          pend[rd_mem[s][i]] = 1'b1;
        end
      end
    end
    if (wr_en_q) begin
      pend[wr_addr_q] = 1'b1;
    end
    pend[0] = 1'b0;
    bus.pending_mask = pend;
  end
`endif

endmodule
